// File: rtl/alu_parity_pipe_if.sv
// alu_parity_pipe_if
//   Handshake and data bundle for alu_parity_pipe.
//   Input side : in_valid/in_ready + func, a, b
//   Output side: out_valid/out_ready + out_result, out_parity, out_carry, out_err
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid && ready are both 1. A producer that raises valid keeps it and
// its payload stable until that transfer. A consumer may change ready freely.
// ready may depend combinationally on the far side's ready (no skid buffer).
interface alu_parity_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_parity;
  logic             out_carry;
  logic             out_err;

  // master: the instruction source and result consumer around the block
  modport master (
    output in_valid, func, a, b, out_ready,
    input  in_ready, out_valid, out_result, out_parity, out_carry, out_err
  );

  // slave: the pipeline itself
  modport slave (
    input  in_valid, func, a, b, out_ready,
    output in_ready, out_valid, out_result, out_parity, out_carry, out_err
  );
endinterface

// File: rtl/alu_parity_pipe.sv
// alu_parity_pipe
//   Three-stage ALU with parity output and valid/ready flow control.
//   S1 registers operands, 3-bit opcode and illegal-code flag.
//   S2 registers the executed ALU result and carry/borrow.
//   S3 registers result, parity, carry and err; these drive the outputs.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : alu_parity_pipe_if.slave (in_* handshake + operands,
//            out_* handshake + result/parity/carry/err)
// Parameters
//   WIDTH      : operand/result width (2..32)
//   ODD_PARITY : 0 -> {result,parity} has even ones, 1 -> odd ones
module alu_parity_pipe #(
  parameter int WIDTH      = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic                clk,
  input logic                reset,
  alu_parity_pipe_if.slave   bus
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  // stage registers
  logic             s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [2:0]       s1_op;
  logic             s1_err;
  logic [WIDTH-1:0] s2_result;
  logic             s2_carry, s2_err;
  logic [WIDTH-1:0] s3_result;
  logic             s3_parity, s3_carry, s3_err;

  // A stage loads when it is empty or its contents leave on the same edge.
  // Chaining these from the output back makes in_ready combinational on
  // out_ready, which is what gives full throughput without a skid buffer.
  logic s1_load, s2_load, s3_load;
  logic in_err;

  assign s3_load = !s3_valid || bus.out_ready;
  assign s2_load = !s2_valid || s3_load;
  assign s1_load = !s1_valid || s2_load;
  assign in_err  = (bus.func > 8'd7);

  assign bus.in_ready   = s1_load;
  assign bus.out_valid  = s3_valid;
  assign bus.out_result = s3_result;
  assign bus.out_parity = s3_parity;
  assign bus.out_carry  = s3_carry;
  assign bus.out_err    = s3_err;

  // S2 execute: add/sub at WIDTH+1 bits; top bit of the difference is the
  // unsigned borrow (a < b).
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  always_comb begin
    sum_w      = {1'b0, s1_a} + {1'b0, s1_b};
    diff_w     = {1'b0, s1_a} - {1'b0, s1_b};
    alu_result = '0;
    alu_carry  = 1'b0;
    case (s1_op)
      OP_ADD:  begin alu_result = sum_w[WIDTH-1:0];  alu_carry = sum_w[WIDTH];  end
      OP_SUB:  begin alu_result = diff_w[WIDTH-1:0]; alu_carry = diff_w[WIDTH]; end
      OP_XOR:  alu_result = s1_a ^ s1_b;
      OP_OR:   alu_result = s1_a | s1_b;
      OP_AND:  alu_result = s1_a & s1_b;
      OP_NOR:  alu_result = ~(s1_a | s1_b);
      OP_NAND: alu_result = ~(s1_a & s1_b);
      OP_XNOR: alu_result = ~(s1_a ^ s1_b);
      default: alu_result = '0;
    endcase
    if (s1_err) begin
      alu_result = '0;
      alu_carry  = 1'b0;
    end
  end

  // S1: data only captured for a real operation so bubbles leave it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.a;
        s1_b   <= bus.b;
        s1_op  <= in_err ? OP_ADD : bus.func[2:0];
        s1_err <= in_err;
      end
    end
  end

  // S2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= alu_result;
        s2_carry  <= alu_carry;
        s2_err    <= s1_err;
      end
    end
  end

  // S3: outputs hold their last value across bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid  <= 1'b0;
      s3_result <= '0;
      s3_parity <= ODD_PARITY;
      s3_carry  <= 1'b0;
      s3_err    <= 1'b0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_result <= s2_result;
        s3_parity <= (^s2_result) ^ ODD_PARITY;
        s3_carry  <= s2_carry;
        s3_err    <= s2_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_parity_pipe.sv
module tb_alu_parity_pipe;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_parity_pipe_if #(.WIDTH(4)) bus4 ();
  alu_parity_pipe_if #(.WIDTH(8)) bus8 ();

  alu_parity_pipe #(.WIDTH(4), .ODD_PARITY(1'b0)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  alu_parity_pipe #(.WIDTH(8), .ODD_PARITY(1'b1)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  // ---------------- bookkeeping ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  logic [6:0] exp_q[$];   // {err, carry, parity, result[3:0]}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model for the 4-bit / even-parity instance, in integer arithmetic.
  function automatic logic [6:0] model(input logic [7:0] f, input logic [3:0] x, input logic [3:0] y);
    int r;
    logic c;
    logic e;
    logic [3:0] rv;
    e = (f > 8'd7);
    c = 1'b0;
    r = 0;
    case (f)
      8'd0: begin r = int'(x) + int'(y); c = (r > 15); end
      8'd1: begin r = int'(x) - int'(y); c = (int'(x) < int'(y)); end
      8'd2: r = int'(x ^ y);
      8'd3: r = int'(x | y);
      8'd4: r = int'(x & y);
      8'd5: r = int'(~(x | y));
      8'd6: r = int'(~(x & y));
      8'd7: r = int'(~(x ^ y));
      default: r = 0;
    endcase
    r  = r & 15;
    rv = r[3:0];
    return {e, c, ^rv, rv};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] f, input logic [3:0] x, input logic [3:0] y);
    bit acc;
    acc = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.func     = f;
    bus4.a        = x;
    bus4.b        = y;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = bus4.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back(model(f, x, y));
    else check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [6:0] obs4;
  logic [6:0] held4;
  bit         hold_pending = 1'b0;

  always @(negedge clk) begin
    obs4 = {bus4.out_err, bus4.out_carry, bus4.out_parity, bus4.out_result};
    if (hold_pending && bus4.out_valid && !reset) check("hold_stable", obs4, held4);
    hold_pending = bus4.out_valid && !bus4.out_ready && !reset;
    held4 = obs4;
    if (!reset && bus4.out_valid && bus4.out_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 32'd1);
      if (exp_q.size() != 0) check("sb_result", obs4, exp_q.pop_front());
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [7:0] rf;
  logic [3:0] ra, rb;
  bit         racc = 1'b0;

  initial begin
    bus4.in_valid = 1'b0; bus4.func = '0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.func = '0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid",  bus4.out_valid,  32'd0);
    check("rst_out_result", bus4.out_result, 32'd0);
    check("rst_out_parity", bus4.out_parity, 32'd0);
    check("rst_out_carry",  bus4.out_carry,  32'd0);
    check("rst_out_err",    bus4.out_err,    32'd0);
    check("rst8_out_parity", bus8.out_parity, 32'd1);
    check("rst8_out_valid",  bus8.out_valid,  32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus4.in_ready, 32'd1);
    tick();

    // latency: add 4+3
    issue(8'd0, 4'd4, 4'd3);
    bus4.in_valid = 1'b0;
    @(negedge clk); check("lat_e0_valid", bus4.out_valid, 32'd0);
    @(negedge clk); check("lat_e1_valid", bus4.out_valid, 32'd0);
    @(negedge clk);
    check("lat_e2_valid",  bus4.out_valid,  32'd1);
    check("lat_result",    bus4.out_result, 32'h7);
    check("lat_parity",    bus4.out_parity, 32'd1);
    check("lat_carry",     bus4.out_carry,  32'd0);
    check("lat_err",       bus4.out_err,    32'd0);
    drain();

    // back-to-back, results on consecutive cycles
    issue(8'd0, 4'd4, 4'd5);
    issue(8'd1, 4'd3, 4'd5);
    issue(8'd7, 4'b1010, 4'b0110);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("b2b0_valid",  bus4.out_valid,  32'd1);
    check("b2b0_result", bus4.out_result, 32'h9);
    check("b2b0_parity", bus4.out_parity, 32'd0);
    check("b2b0_carry",  bus4.out_carry,  32'd0);
    @(negedge clk);
    check("b2b1_valid",  bus4.out_valid,  32'd1);
    check("b2b1_result", bus4.out_result, 32'hE);
    check("b2b1_parity", bus4.out_parity, 32'd1);
    check("b2b1_borrow", bus4.out_carry,  32'd1);
    @(negedge clk);
    check("b2b2_valid",  bus4.out_valid,  32'd1);
    check("b2b2_result", bus4.out_result, 32'h3);
    check("b2b2_parity", bus4.out_parity, 32'd0);
    drain();

    // backpressure: fill three stages, fourth waits
    bus4.out_ready = 1'b0;
    issue(8'd0, 4'd1, 4'd2);
    issue(8'd1, 4'd9, 4'd4);
    issue(8'd4, 4'd5, 4'd6);
    bus4.in_valid = 1'b1; bus4.func = 8'd3; bus4.a = 4'd12; bus4.b = 4'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready",  bus4.in_ready,   32'd0);
      check("bp_out_valid", bus4.out_valid,  32'd1);
      check("bp_held",      bus4.out_result, 32'h3);
    end
    tick();
    bus4.out_ready = 1'b1;
    issue(8'd3, 4'd12, 4'd10);
    drain();

    // illegal code then legal add with carry
    issue(8'd9, 4'd15, 4'd15);
    issue(8'd0, 4'd15, 4'd1);
    bus4.in_valid = 1'b0;
    @(negedge clk); check("err_pre_valid", bus4.out_valid, 32'd0);
    @(negedge clk);
    check("err_err",    bus4.out_err,    32'd1);
    check("err_result", bus4.out_result, 32'h0);
    check("err_carry",  bus4.out_carry,  32'd0);
    check("err_parity", bus4.out_parity, 32'd0);
    @(negedge clk);
    check("add_err",    bus4.out_err,    32'd0);
    check("add_result", bus4.out_result, 32'h0);
    check("add_carry",  bus4.out_carry,  32'd1);
    drain();

    // reset with three operations in flight
    bus4.out_ready = 1'b0;
    issue(8'd0, 4'd1, 4'd1);
    issue(8'd2, 4'd3, 4'd5);
    issue(8'd3, 4'd8, 4'd1);
    bus4.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_out_valid",  bus4.out_valid,  32'd0);
    check("midrst_out_result", bus4.out_result, 32'd0);
    check("midrst_in_ready",   bus4.in_ready,   32'd1);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_valid", bus4.out_valid, 32'd0);
    end
    tick();
    issue(8'd2, 4'b1100, 4'b1010);
    bus4.in_valid = 1'b0;
    @(negedge clk); check("fresh_e0_valid", bus4.out_valid, 32'd0);
    @(negedge clk); check("fresh_e1_valid", bus4.out_valid, 32'd0);
    @(negedge clk);
    check("fresh_e2_valid", bus4.out_valid,  32'd1);
    check("fresh_result",   bus4.out_result, 32'h6);
    drain();

    // 8-bit odd-parity instance: nand F0,FF
    bus8.in_valid = 1'b1; bus8.func = 8'd6; bus8.a = 8'hF0; bus8.b = 8'hFF;
    @(negedge clk);
    check("w8_in_ready", bus8.in_ready, 32'd1);
    tick();
    bus8.in_valid = 1'b0;
    @(negedge clk); check("w8_e0_valid", bus8.out_valid, 32'd0);
    @(negedge clk); check("w8_e1_valid", bus8.out_valid, 32'd0);
    @(negedge clk);
    check("w8_valid",  bus8.out_valid,  32'd1);
    check("w8_result", bus8.out_result, 32'h0F);
    check("w8_parity", bus8.out_parity, 32'd1);
    check("w8_carry",  bus8.out_carry,  32'd0);
    tick();

    // random traffic with random backpressure
    bus4.in_valid = 1'b0;
    racc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus4.in_valid || racc) begin
        rf = 8'($urandom_range(0, 10));
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        bus4.func = rf; bus4.a = ra; bus4.b = rb;
        bus4.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      racc = bus4.in_valid && bus4.in_ready;
      @(posedge clk);
      #1;
      if (racc) exp_q.push_back(model(bus4.func, bus4.a, bus4.b));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
